alarm_led_ctrl: RTL

- Multi-channel alarm indicator driver; next generation of the single-channel countdown LED blinker.
- Each channel watches a level-sensitive `ring` request, drives its LED in a latched mode (steady, slow blink, fast blink) for a bounded time, and supports early acknowledge.
- Sits between the alarm/countdown comparators and the board LED pins; all channels share one clock.

---
 rtl/alarm_led_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alarm_led_ctrl.sv
// Multi-channel alarm LED driver: per-channel IDLE/ACTIVE/DONE with latched blink mode and timeout.
// Optional shared buzzer output enabled by defining ALARM_BUZZER_EN.
module alarm_led_ctrl #(
  parameter int unsigned CH            = 4,
  parameter int unsigned SLOW_HALF_CYC = 2500000,
  parameter int unsigned FAST_HALF_CYC = 625000,
  parameter int unsigned DURATION_CYC  = 25000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   ring,
  input  logic [CH-1:0]   ack,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   led,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   done
`ifdef ALARM_BUZZER_EN
  ,
  output logic            buzzer
`endif
);

  localparam int unsigned DW = $clog2(DURATION_CYC);
  localparam int unsigned PW = $clog2(SLOW_HALF_CYC);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] M_STEADY = 2'd0;
  localparam logic [1:0] M_SLOW   = 2'd1;
  localparam logic [1:0] M_FAST   = 2'd2;
  localparam logic [1:0] M_SILENT = 2'd3;

  logic [1:0]    state_q [CH];
  logic [1:0]    state_n [CH];
  logic [1:0]    mode_q  [CH];
  logic [1:0]    mode_n  [CH];
  logic [DW-1:0] dur_q   [CH];
  logic [DW-1:0] dur_n   [CH];
  logic [PW-1:0] ph_q    [CH];
  logic [PW-1:0] ph_n    [CH];
  logic [CH-1:0] led_n;
  logic [CH-1:0] busy_n;
  logic [CH-1:0] done_n;

  // Last phase count before a toggle; only the fast mode uses the short half-period.
  function automatic logic [PW-1:0] half_last(input logic [1:0] m);
    return (m == M_FAST) ? PW'(FAST_HALF_CYC - 1) : PW'(SLOW_HALF_CYC - 1);
  endfunction

  // Per-channel next-state and registered-output values.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_n[i] = state_q[i];
      mode_n[i]  = mode_q[i];
      dur_n[i]   = dur_q[i];
      ph_n[i]    = ph_q[i];
      led_n[i]   = led[i];
      busy_n[i]  = busy[i];
      done_n[i]  = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          dur_n[i]  = '0;
          ph_n[i]   = '0;
          led_n[i]  = 1'b0;
          busy_n[i] = 1'b0;
          if (ring[i]) begin
            state_n[i] = S_ACTIVE;
            mode_n[i]  = mode[2*i +: 2];
            led_n[i]   = (mode[2*i +: 2] != M_SILENT);
            busy_n[i]  = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!ring[i] || ack[i] || (dur_q[i] == DW'(DURATION_CYC - 1))) begin
            // A dropped ring returns silently; ack or timeout reports completion.
            state_n[i] = ring[i] ? S_DONE : S_IDLE;
            done_n[i]  = ring[i];
            dur_n[i]   = '0;
            ph_n[i]    = '0;
            led_n[i]   = 1'b0;
            busy_n[i]  = 1'b0;
          end else begin
            dur_n[i] = dur_q[i] + DW'(1);
            if (ph_q[i] == half_last(mode_q[i])) begin
              ph_n[i] = '0;
              if (mode_q[i] == M_SLOW || mode_q[i] == M_FAST) led_n[i] = ~led[i];
            end else begin
              ph_n[i] = ph_q[i] + PW'(1);
            end
            if (mode_q[i] == M_STEADY) led_n[i] = 1'b1;
            if (mode_q[i] == M_SILENT) led_n[i] = 1'b0;
          end
        end
        S_DONE: begin
          dur_n[i]  = '0;
          ph_n[i]   = '0;
          led_n[i]  = 1'b0;
          busy_n[i] = 1'b0;
          if (!ring[i]) state_n[i] = S_IDLE;
        end
        default: begin
          state_n[i] = S_IDLE;
          dur_n[i]   = '0;
          ph_n[i]    = '0;
          led_n[i]   = 1'b0;
          busy_n[i]  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= S_IDLE;
        mode_q[i]  <= '0;
        dur_q[i]   <= '0;
        ph_q[i]    <= '0;
      end
      led  <= '0;
      busy <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_n[i];
        mode_q[i]  <= mode_n[i];
        dur_q[i]   <= dur_n[i];
        ph_q[i]    <= ph_n[i];
      end
      led  <= led_n;
      busy <= busy_n;
      done <= done_n;
    end
  end

`ifdef ALARM_BUZZER_EN
  localparam int unsigned FW = $clog2(FAST_HALF_CYC);

  logic [FW-1:0] sq_cnt_q;
  logic [FW-1:0] sq_cnt_n;
  logic          sq_wave_q;
  logic          sq_wave_n;
  logic          any_active;
  logic          audible_n;

  // Shared square wave runs only while some channel is active; restarts high.
  always_comb begin
    any_active = 1'b0;
    audible_n  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (state_q[i] == S_ACTIVE) any_active = 1'b1;
      if (state_n[i] == S_ACTIVE && mode_n[i] != M_SILENT) audible_n = 1'b1;
    end
    sq_cnt_n  = '0;
    sq_wave_n = 1'b1;
    if (any_active) begin
      sq_wave_n = sq_wave_q;
      if (sq_cnt_q == FW'(FAST_HALF_CYC - 1)) begin
        sq_wave_n = ~sq_wave_q;
      end else begin
        sq_cnt_n = sq_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_cnt_q  <= '0;
      sq_wave_q <= 1'b1;
      buzzer    <= 1'b0;
    end else begin
      sq_cnt_q  <= sq_cnt_n;
      sq_wave_q <= sq_wave_n;
      buzzer    <= audible_n & sq_wave_n;
    end
  end
`endif

endmodule
